// File: rtl/cpu_rst_seq_pkg.sv
// cpu_rst_seq_pkg
//   Shared definitions for the CPU reset sequencer: FSM state encoding and
//   the elaboration-time check that the counter width can hold every count.
package cpu_rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_LOCK  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_RUN   = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  // True when 2^cnt_width exceeds the largest count the block must reach.
  function automatic bit cnt_width_ok(input int unsigned cnt_width,
                                      input int unsigned timeout,
                                      input int unsigned lock_edges,
                                      input int unsigned hold_edges);
    int unsigned m;
    m = timeout;
    if (lock_edges > m) m = lock_edges;
    if (hold_edges > m) m = hold_edges;
    return (64'(1) << cnt_width) > 64'(m);
  endfunction

endpackage

// File: rtl/edge_gap_mon.sv
// edge_gap_mon
//   Rising-edge detector and stall monitor for the divided CPU clock, which
//   is treated as plain data in the i_clk domain.
//   i_clk     : system clock
//   i_rst_n   : synchronous active-low reset
//   i_div_clk : divided clock, already registered in i_clk domain
//   o_rise    : combinational, high in the cycle div_clk is first seen high
//   o_stall   : one-cycle pulse TIMEOUT cycles after the last rise
module edge_gap_mon #(
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_div_clk,
  output logic o_rise,
  output logic o_stall
);

  localparam logic [CNT_WIDTH-1:0] GAP_MAX  = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST = CNT_WIDTH'(TIMEOUT - 1);

  logic                 r_div_prev;
  logic [CNT_WIDTH-1:0] r_gap;

  assign o_rise  = i_div_clk & ~r_div_prev;
  // The gap saturates at TIMEOUT, so this compare can only match once per stall.
  assign o_stall = ~o_rise & (r_gap == GAP_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div_prev <= 1'b0;
      r_gap      <= '0;
    end else begin
      r_div_prev <= i_div_clk;
      if (o_rise)
        r_gap <= '0;
      else if (r_gap != GAP_MAX)
        r_gap <= r_gap + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_rst_seq.sv
// cpu_rst_seq
//   Reset sequencer and clock monitor for the 8051 core. Locks onto the
//   divided clock, holds the core in reset for HOLD_EDGES divided periods,
//   then releases it; a stalled divided clock re-asserts reset and sets a
//   sticky fault flag.
//   clk_in      : 50 MHz system clock (only clock)
//   rst_n       : synchronous active-low reset
//   div_clk     : divided CPU clock, registered in clk_in domain
//   ext_rst_req : level request to re-reset the CPU (honoured in HOLD/RUN)
//   cpu_rst     : active-high reset to the core
//   cpu_ce      : one-cycle pulse per div_clk rise while running
//   clk_ok      : high in HOLD and RUN
//   clk_fault   : sticky stall flag, cleared only by rst_n
module cpu_rst_seq
  import cpu_rst_seq_pkg::*;
#(
  parameter int unsigned LOCK_EDGES = 4,
  parameter int unsigned HOLD_EDGES = 16,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic div_clk,
  input  logic ext_rst_req,
  output logic cpu_rst,
  output logic cpu_ce,
  output logic clk_ok,
  output logic clk_fault
);

  localparam bit CNT_OK = cnt_width_ok(CNT_WIDTH, TIMEOUT, LOCK_EDGES, HOLD_EDGES);

  if (!CNT_OK) begin : g_cnt_width_bad
    $error("cpu_rst_seq: CNT_WIDTH too small for TIMEOUT/LOCK_EDGES/HOLD_EDGES");
  end

  localparam logic [CNT_WIDTH-1:0] LOCK_TGT = CNT_WIDTH'(LOCK_EDGES);
  localparam logic [CNT_WIDTH-1:0] HOLD_TGT = CNT_WIDTH'(HOLD_EDGES);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_lock_cnt, w_lock_nxt, w_lock_inc;
  logic [CNT_WIDTH-1:0] r_hold_cnt, w_hold_nxt, w_hold_inc;
  logic                 r_cpu_rst, r_cpu_ce, r_clk_ok, r_clk_fault;
  logic                 w_rise, w_stall;

  edge_gap_mon #(
    .TIMEOUT   (TIMEOUT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_mon (
    .i_clk     (clk_in),
    .i_rst_n   (rst_n),
    .i_div_clk (div_clk),
    .o_rise    (w_rise),
    .o_stall   (w_stall)
  );

  assign w_lock_inc = r_lock_cnt + CNT_WIDTH'(1);
  assign w_hold_inc = r_hold_cnt + CNT_WIDTH'(1);

  // Priority within a cycle: stall, then ext_rst_req, then rise-driven advance.
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_cnt;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      ST_LOCK: begin
        if (w_stall) begin
          w_lock_nxt = '0;
        end else if (w_rise) begin
          if (w_lock_inc == LOCK_TGT) begin
            w_state_nxt = ST_HOLD;
            w_lock_nxt  = '0;
            w_hold_nxt  = '0;
          end else begin
            w_lock_nxt = w_lock_inc;
          end
        end
      end
      ST_HOLD: begin
        if (w_stall) begin
          w_state_nxt = ST_FAULT;
        end else if (ext_rst_req) begin
          w_hold_nxt = '0;
        end else if (w_rise) begin
          if (w_hold_inc == HOLD_TGT) begin
            w_state_nxt = ST_RUN;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt = w_hold_inc;
          end
        end
      end
      ST_RUN: begin
        if (w_stall) begin
          w_state_nxt = ST_FAULT;
        end else if (ext_rst_req) begin
          w_state_nxt = ST_HOLD;
          w_hold_nxt  = '0;
        end
      end
      ST_FAULT: begin
        // The recovering rise only re-enters LOCK; it is not counted.
        if (w_rise) begin
          w_state_nxt = ST_LOCK;
          w_lock_nxt  = '0;
        end
      end
      default: w_state_nxt = ST_LOCK;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state     <= ST_LOCK;
      r_lock_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_cpu_rst   <= 1'b1;
      r_cpu_ce    <= 1'b0;
      r_clk_ok    <= 1'b0;
      r_clk_fault <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_cpu_rst  <= (w_state_nxt != ST_RUN);
      r_cpu_ce   <= w_rise & (w_state_nxt == ST_RUN);
      r_clk_ok   <= (w_state_nxt == ST_HOLD) | (w_state_nxt == ST_RUN);
      if ((w_state_nxt == ST_FAULT) && (r_state != ST_FAULT))
        r_clk_fault <= 1'b1;
    end
  end

  assign cpu_rst   = r_cpu_rst;
  assign cpu_ce    = r_cpu_ce;
  assign clk_ok    = r_clk_ok;
  assign clk_fault = r_clk_fault;

endmodule

// File: tb/tb_cpu_rst_seq.sv
// tb_cpu_rst_seq
//   Directed bench for cpu_rst_seq. Every change of the output vector
//   {cpu_rst, clk_ok, clk_fault, cpu_ce} is an event; the stimulus process
//   queues the expected (cycle, value) of each event as it drives the cycle
//   that causes it, and a monitor pops and compares on each observed change.
//   Cycle numbers in the table are relative to the first cycle with rst_n high.
module tb_cpu_rst_seq;

  logic clk;
  logic rst_n;
  logic div_clk;
  logic ext_rst_req;
  logic cpu_rst;
  logic cpu_ce;
  logic clk_ok;
  logic clk_fault;

  cpu_rst_seq #(
    .LOCK_EDGES (4),
    .HOLD_EDGES (16),
    .TIMEOUT    (64),
    .CNT_WIDTH  (8)
  ) dut (
    .clk_in      (clk),
    .rst_n       (rst_n),
    .div_clk     (div_clk),
    .ext_rst_req (ext_rst_req),
    .cpu_rst     (cpu_rst),
    .cpu_ce      (cpu_ce),
    .clk_ok      (clk_ok),
    .clk_fault   (clk_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of posedges seen; inputs driven at a negedge belong to cycle cyc.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int REL0    = 4;    // absolute cycle of rst_n release
  localparam int RST_MID = 742;  // one-cycle reset pulse, hold_cnt==7
  localparam int N_EV    = 27;
  localparam int END_REL = 904;

  typedef struct {
    int         stamp;
    logic [3:0] val;
    int         idx;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected events: {cpu_rst, clk_ok, clk_fault, cpu_ce}
  int ev_rel [N_EV] = '{
    -4,  28,
    156, 157, 164, 165, 172, 173, 180, 181,
    184,
    308, 309, 316, 317,
    380, 432,
    560, 561, 568, 569,
    632, 682, 742, 770,
    898, 899
  };
  logic [3:0] ev_val [N_EV] = '{
    4'b1000, 4'b1100,
    4'b0101, 4'b0100, 4'b0101, 4'b0100, 4'b0101, 4'b0100, 4'b0101, 4'b0100,
    4'b1100,
    4'b0101, 4'b0100, 4'b0101, 4'b0100,
    4'b1010, 4'b1110,
    4'b0111, 4'b0110, 4'b0111, 4'b0110,
    4'b1010, 4'b1110, 4'b1000, 4'b1100,
    4'b0101, 4'b0100
  };

  // Three bursts of div_clk (period 8, high 4): first/last rise of each.
  function automatic logic div_at(input int rel);
    int first [3] = '{4, 400, 650};
    int last  [3] = '{316, 568, 898};
    for (int s = 0; s < 3; s++) begin
      if (rel >= first[s] && rel <= last[s] + 3 && ((rel - first[s]) % 8) < 4)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  int ptr = 0;

  task automatic drive_cycle(input int c);
    int rel;
    exp_t e;
    rel         = c - REL0;
    rst_n       = !(rel < 0 || rel == RST_MID);
    div_clk     = (rel >= 0) ? div_at(rel) : 1'b0;
    ext_rst_req = (rel >= 184 && rel <= 186) || (rel == 632);
    while (ptr < N_EV && ev_rel[ptr] == rel) begin
      e.stamp = c;
      e.val   = ev_val[ptr];
      e.idx   = ptr;
      q.push_back(e);
      ptr++;
    end
  endtask

  // Stimulus
  initial begin
    exp_t e;
    drive_cycle(0);
    while (cyc < REL0 + END_REL) begin
      @(negedge clk);
      drive_cycle(cyc);
    end
    repeat (3) @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL ev%0d_missing: got no change, required value %b at rel cycle %0d",
               e.idx, e.val, e.stamp - REL0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Monitor
  initial begin
    logic [3:0] prev;
    logic [3:0] v;
    bit         first;
    exp_t       e;
    int         st;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(posedge clk);
      #1;
      v  = {cpu_rst, clk_ok, clk_fault, cpu_ce};
      st = cyc - 1;
      if (first || v !== prev) begin
        first = 1'b0;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got value %b at rel cycle %0d, required no change",
                   v, st - REL0);
        end else begin
          e = q.pop_front();
          if (e.stamp != st || v !== e.val) begin
            n_fail++;
            $display("FAIL ev%0d: got value %b at rel cycle %0d, required value %b at rel cycle %0d",
                     e.idx, v, st - REL0, e.val, e.stamp - REL0);
          end
        end
      end
      prev = v;
    end
  end

endmodule
